// File: rtl/door_motor_actuator.sv
// rtl/door_motor_actuator.sv - sliding-door motor/sensor plant model; optional obstruction input via DOOR_OBSTRUCT_EN
module door_motor_actuator #(
    parameter int POS_W       = 8,
    parameter int OPEN_POS    = 200,
    parameter int STEP_DIV    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int DEAD_CYC    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mo,
    input  logic             mc,
    input  logic             ms,
`ifdef DOOR_OBSTRUCT_EN
    input  logic             obstruct,
    output logic             stalled,
`endif
    output logic [POS_W-1:0] position,
    output logic             door_opened,
    output logic             door_closed,
    output logic             timer_expired,
    output logic             moving,
    output logic             dir,
    output logic             fault
);
    localparam int PS_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DC_W   = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [POS_W-1:0]  OPEN_P    = POS_W'(OPEN_POS);
    localparam logic [PS_W-1:0]   STEP_LAST = PS_W'(STEP_DIV - 1);
    localparam logic [DC_W-1:0]   DEAD_LAST = DC_W'(DEAD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(HOLD_CYCLES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_CLOSING = 3'd2;
    localparam logic [2:0] S_DEAD    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    logic [2:0]        state, state_n;
    logic [PS_W-1:0]   presc, presc_n;
    logic [DC_W-1:0]   dead_cnt, dead_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [POS_W-1:0]  pos_n;
    logic              dir_n;
    logic              blocked;
    logic              obstruct_i;

    logic cmd_open, cmd_close, cmd_ill;
    assign cmd_open  = mo & ~mc & ~ms;
    assign cmd_close = mc & ~mo & ~ms;
    assign cmd_ill   = mo & mc & ~ms;

`ifdef DOOR_OBSTRUCT_EN
    assign obstruct_i = obstruct;
`else
    assign obstruct_i = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pos_n   = position;
        presc_n = presc;
        dead_n  = dead_cnt;
        dir_n   = dir;
        blocked = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_ill) begin
                    state_n = S_FAULT;
                end else if (cmd_open && position != OPEN_P) begin
                    state_n = S_OPENING;
                    dir_n   = 1'b1;
                    presc_n = '0;
                end else if (cmd_close && position != '0) begin
                    state_n = S_CLOSING;
                    dir_n   = 1'b0;
                    presc_n = '0;
                end
            end
            S_OPENING: begin
                if (cmd_ill) begin
                    state_n = S_FAULT;
                end else if (cmd_open) begin
                    if (presc == STEP_LAST) begin
                        presc_n = '0;
                        pos_n   = position + 1'b1;
                        if (pos_n == OPEN_P) state_n = S_IDLE;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end else if (cmd_close) begin
                    state_n = S_DEAD;
                    dead_n  = '0;
                    presc_n = '0;
                end else begin
                    state_n = S_IDLE;
                    presc_n = '0;
                end
            end
            S_CLOSING: begin
                if (cmd_ill) begin
                    state_n = S_FAULT;
                end else if (cmd_close) begin
                    // an obstruction freezes closing travel in place
                    if (obstruct_i) begin
                        blocked = 1'b1;
                    end else if (presc == STEP_LAST) begin
                        presc_n = '0;
                        pos_n   = position - 1'b1;
                        if (pos_n == '0) state_n = S_IDLE;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                end else if (cmd_open) begin
                    state_n = S_DEAD;
                    dead_n  = '0;
                    presc_n = '0;
                end else begin
                    state_n = S_IDLE;
                    presc_n = '0;
                end
            end
            S_DEAD: begin
                if (ms) begin
                    state_n = S_IDLE;
                end else if (cmd_ill) begin
                    state_n = S_FAULT;
                end else if (dead_cnt == DEAD_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    dead_n = dead_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            position      <= '0;
            presc         <= '0;
            dead_cnt      <= '0;
            hold_cnt      <= '0;
            dir           <= 1'b0;
            door_opened   <= 1'b0;
            door_closed   <= 1'b1;
            timer_expired <= 1'b0;
            moving        <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state       <= state_n;
            position    <= pos_n;
            presc       <= presc_n;
            dead_cnt    <= dead_n;
            dir         <= dir_n;
            door_opened <= (pos_n == OPEN_P);
            door_closed <= (pos_n == '0);
            moving      <= (state_n == S_OPENING) || (state_n == S_CLOSING);
            fault       <= (state_n == S_FAULT);
            // hold timer counts edges spent fully open, clearing as the door leaves
            if (pos_n != OPEN_P) begin
                hold_cnt      <= '0;
                timer_expired <= 1'b0;
            end else if (position == OPEN_P && hold_cnt != HOLD_FULL) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_FULL - 1'b1) timer_expired <= 1'b1;
            end
        end
    end

`ifdef DOOR_OBSTRUCT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stalled <= 1'b0;
        else     stalled <= blocked;
    end
`else
    logic unused_blocked;
    assign unused_blocked = blocked;
`endif

endmodule

// File: tb/tb_door_motor_actuator.sv
// tb/tb_door_motor_actuator.sv - directed and randomized bench for door_motor_actuator against a travel-time reference model
module tb_door_motor_actuator;
    localparam int POS_W = 8, OPEN_POS = 200, STEP_DIV = 4, HOLD_CYCLES = 16, DEAD_CYC = 2;
    localparam int FULL_TRAVEL = OPEN_POS * STEP_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mo = 1'b0, mc = 1'b0, ms = 1'b0;
    logic obstruct = 1'b0;
    logic stalled;
    logic [POS_W-1:0] position;
    logic door_opened, door_closed, timer_expired, moving, dir, fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    door_motor_actuator #(
        .POS_W(POS_W), .OPEN_POS(OPEN_POS), .STEP_DIV(STEP_DIV),
        .HOLD_CYCLES(HOLD_CYCLES), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk(clk), .rst(rst), .mo(mo), .mc(mc), .ms(ms),
`ifdef DOOR_OBSTRUCT_EN
        .obstruct(obstruct), .stalled(stalled),
`endif
        .position(position), .door_opened(door_opened), .door_closed(door_closed),
        .timer_expired(timer_expired), .moving(moving), .dir(dir), .fault(fault)
    );
`ifndef DOOR_OBSTRUCT_EN
    assign stalled = 1'b0;
`endif

    // Reference model: travel is tracked as elapsed cycles in the current run;
    // a step lands every STEP_DIV-th cycle of that run.
    localparam int M_IDLE = 0, M_OPEN = 1, M_CLOSE = 2, M_DEAD = 3, M_FAULT = 4;
    int m_mode, m_pos, m_run, m_dead, m_held;
    bit m_dir;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; m_pos = 0; m_run = 0; m_dead = 0; m_held = 0; m_dir = 0;
        end else begin
            bit was_open, o, c, il;
            was_open = (m_pos == OPEN_POS);
            o  = mo && !mc && !ms;
            c  = mc && !mo && !ms;
            il = mo && mc && !ms;
            if (m_mode != M_FAULT) begin
                if (il) m_mode = M_FAULT;
                else if (m_mode == M_IDLE) begin
                    if (o && m_pos < OPEN_POS) begin m_mode = M_OPEN; m_dir = 1; m_run = 0; end
                    else if (c && m_pos > 0)   begin m_mode = M_CLOSE; m_dir = 0; m_run = 0; end
                end else if (m_mode == M_OPEN) begin
                    if (o) begin
                        m_run++;
                        if (m_run % STEP_DIV == 0) m_pos++;
                        if (m_pos == OPEN_POS) m_mode = M_IDLE;
                    end else if (c) begin m_mode = M_DEAD; m_dead = 0; end
                    else m_mode = M_IDLE;
                end else if (m_mode == M_CLOSE) begin
                    if (c) begin
                        if (!obstruct) begin
                            m_run++;
                            if (m_run % STEP_DIV == 0) m_pos--;
                            if (m_pos == 0) m_mode = M_IDLE;
                        end
                    end else if (o) begin m_mode = M_DEAD; m_dead = 0; end
                    else m_mode = M_IDLE;
                end else if (m_mode == M_DEAD) begin
                    if (ms) m_mode = M_IDLE;
                    else begin m_dead++; if (m_dead == DEAD_CYC) m_mode = M_IDLE; end
                end
            end
            if (m_pos != OPEN_POS) m_held = 0;
            else if (was_open) m_held++;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic o, input logic c, input logic s);
        mo = o; mc = c; ms = s;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_cmd(0, 0, 0);
        obstruct = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic go_to(input int target);
        for (int i = 0; i < 4 * FULL_TRAVEL && position != POS_W'(target); i++) tick();
    endtask

    task automatic test_reset();
        set_cmd(1, 0, 0);
        repeat (10) tick();
        checks++;
        if (position !== 8'd2) begin errors++; $display("FAIL pre_reset_pos got=%0d want=2", position); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({position, door_opened, door_closed, timer_expired, moving, dir, fault} !== {8'd0, 6'b010000}) begin
            errors++;
            $display("FAIL async_reset got pos=%0d op=%b cl=%b te=%b mv=%b dir=%b f=%b want pos=0 cl=1 others 0",
                     position, door_opened, door_closed, timer_expired, moving, dir, fault);
        end
        @(negedge clk);
        set_cmd(0, 0, 0);
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (position !== 8'd0 || door_closed !== 1'b1) begin
            errors++; $display("FAIL post_reset_idle got pos=%0d cl=%b want 0/1", position, door_closed);
        end
    endtask

    task automatic test_full_open();
        int n, first_step;
        n = 0; first_step = -1;
        set_cmd(1, 0, 0);
        while (!door_opened && n < 2 * FULL_TRAVEL) begin
            tick(); n++;
            if (first_step < 0 && !door_closed) first_step = n;
        end
        checks++;
        if (first_step != 1 + STEP_DIV) begin errors++; $display("FAIL first_step got=%0d want=%0d", first_step, 1 + STEP_DIV); end
        checks++;
        if (n != 1 + FULL_TRAVEL || moving !== 1'b0) begin
            errors++; $display("FAIL full_open got edges=%0d mv=%b want %0d/0", n, moving, 1 + FULL_TRAVEL);
        end
        n = 0;
        while (!timer_expired && n < 100) begin tick(); n++; end
        checks++;
        if (n != HOLD_CYCLES) begin errors++; $display("FAIL hold_timer got=%0d want=%0d", n, HOLD_CYCLES); end
        set_cmd(0, 1, 0);
        repeat (STEP_DIV) tick();
        checks++;
        if (timer_expired !== 1'b1 || position !== 8'(OPEN_POS)) begin
            errors++; $display("FAIL te_before_step got te=%b pos=%0d want 1/%0d", timer_expired, position, OPEN_POS);
        end
        tick();
        checks++;
        if (timer_expired !== 1'b0 || position !== 8'(OPEN_POS - 1)) begin
            errors++; $display("FAIL te_first_step got te=%b pos=%0d want 0/%0d", timer_expired, position, OPEN_POS - 1);
        end
        n = 1 + STEP_DIV;
        while (!door_closed && n < 2 * FULL_TRAVEL) begin tick(); n++; end
        checks++;
        if (n != 1 + FULL_TRAVEL || door_opened !== 1'b0) begin
            errors++; $display("FAIL full_close got edges=%0d op=%b want %0d/0", n, door_opened, 1 + FULL_TRAVEL);
        end
    endtask

    task automatic test_stop_resume();
        int n;
        set_cmd(1, 0, 0);
        go_to(50);
        set_cmd(1, 0, 1);
        repeat (12) tick();
        checks++;
        if (position !== 8'd50 || moving !== 1'b0) begin
            errors++; $display("FAIL stop_hold got pos=%0d mv=%b want 50/0", position, moving);
        end
        set_cmd(1, 0, 0);
        n = 0;
        while (position == 8'd50 && n < 50) begin tick(); n++; end
        checks++;
        if (n != 1 + STEP_DIV || position !== 8'd51) begin
            errors++; $display("FAIL resume got edges=%0d pos=%0d want %0d/51", n, position, 1 + STEP_DIV);
        end
    endtask

    task automatic test_reversal();
        logic [3:0] mv_seq;
        int maxpos;
        go_to(100);
        set_cmd(0, 1, 0);
        maxpos = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mv_seq[i] = moving;
        end
        checks++;
        if (mv_seq !== 4'b1000) begin errors++; $display("FAIL reversal_dead got moving seq=%b want 1000", mv_seq); end
        for (int i = 0; i < 2 * FULL_TRAVEL && position != 0; i++) begin
            tick();
            if (int'(position) > maxpos) maxpos = int'(position);
        end
        checks++;
        if (maxpos > 100 || position !== 8'd0 || dir !== 1'b0) begin
            errors++; $display("FAIL reversal_close got max=%0d pos=%0d dir=%b want <=100/0/0", maxpos, position, dir);
        end
    endtask

    task automatic test_illegal();
        set_cmd(1, 0, 0);
        go_to(30);
        set_cmd(1, 1, 0);
        tick();
        checks++;
        if (fault !== 1'b1 || moving !== 1'b0) begin errors++; $display("FAIL illegal_fault got f=%b mv=%b want 1/0", fault, moving); end
        for (int i = 0; i < 40; i++) begin
            set_cmd(1'($urandom), 1'($urandom), 1'($urandom));
            tick();
        end
        checks++;
        if (position !== 8'd30 || fault !== 1'b1) begin
            errors++; $display("FAIL fault_frozen got pos=%0d f=%b want 30/1", position, fault);
        end
        do_reset();
        set_cmd(1, 0, 0);
        go_to(10);
        set_cmd(1, 1, 1);
        repeat (8) tick();
        checks++;
        if (fault !== 1'b0 || moving !== 1'b0 || position !== 8'd10) begin
            errors++; $display("FAIL all_high_stop got f=%b mv=%b pos=%0d want 0/0/10", fault, moving, position);
        end
    endtask

`ifdef DOOR_OBSTRUCT_EN
    task automatic test_obstruct();
        int n;
        set_cmd(1, 0, 0);
        go_to(80);
        set_cmd(0, 1, 0);
        while (!moving && n < 20) begin tick(); n++; end
        obstruct = 1'b1;
        repeat (20) tick();
        checks++;
        if (position !== 8'd80 || stalled !== 1'b1) begin
            errors++; $display("FAIL obstruct_hold got pos=%0d st=%b want 80/1", position, stalled);
        end
        obstruct = 1'b0;
        tick();
        checks++;
        if (stalled !== 1'b0) begin errors++; $display("FAIL obstruct_clear got st=%b want 0", stalled); end
        n = 0;
        while (position == 8'd80 && n < 20) begin tick(); n++; end
        checks++;
        if (position !== 8'd79) begin errors++; $display("FAIL obstruct_resume got pos=%0d want 79", position); end
    endtask
`endif

    task automatic test_random();
        int r, len;
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 80);
            if (r < 40)      set_cmd(1, 0, 0);
            else if (r < 80) set_cmd(0, 1, 0);
            else if (r < 88) set_cmd(r[0], r[1], 1);
            else if (r < 97) set_cmd(0, 0, 0);
            else             set_cmd(1, 1, 0);
            if (m_mode == M_FAULT && r[0]) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
            for (int i = 0; i < len; i++) begin
`ifdef DOOR_OBSTRUCT_EN
                obstruct = ($urandom_range(0, 9) == 0);
`endif
                tick();
                checks++;
                if ({position, door_opened, door_closed, timer_expired, moving, dir, fault} !==
                    {8'(m_pos), m_pos == OPEN_POS, m_pos == 0, m_held >= HOLD_CYCLES,
                     m_mode == M_OPEN || m_mode == M_CLOSE, m_dir, m_mode == M_FAULT}) begin
                    errors++;
                    $display("FAIL random seg=%0d got pos=%0d op=%b cl=%b te=%b mv=%b dir=%b f=%b want pos=%0d te=%0b mode=%0d dir=%b",
                             seg, position, door_opened, door_closed, timer_expired, moving, dir, fault,
                             m_pos, m_held >= HOLD_CYCLES, m_mode, m_dir);
                end
            end
        end
        obstruct = 1'b0;
    endtask

    initial begin
        do_reset();
        test_reset();
        test_full_open();
        test_stop_resume();
        test_reversal();
        do_reset();
        test_illegal();
`ifdef DOOR_OBSTRUCT_EN
        do_reset();
        test_obstruct();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
